// File: rtl/uart_tx.sv
// UART transmitter: serialises one character per valid/ready handshake as
// start, DATA_BITS data (LSB first), optional parity, and STOP_BITS stop bits.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_br_en,
    input  logic       tx_br_stb,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [3:0] DATA_BITS_C  = 4'(DATA_BITS);
    localparam logic [3:0] STOP_BITS_C  = 4'(STOP_BITS);
    localparam logic       PARITY_EN_C  = (PARITY_EN != 0);
    localparam logic       PARITY_ODD_C = (PARITY_ODD != 0);
    localparam logic [7:0] DATA_MASK    = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] shift_r, shift_s;
    logic [3:0] cnt_r, cnt_s;
    logic       par_r, par_s;
    logic       txd_r, txd_s;
    logic       br_en_r, br_en_s;

    function automatic logic par_fold(input logic acc, input logic bit_v);
        return acc ^ bit_v;
    endfunction

    // State, datapath and registered line outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            shift_r <= 8'd0;
            cnt_r   <= 4'd0;
            par_r   <= 1'b0;
            txd_r   <= 1'b1;
            br_en_r <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
            par_r   <= par_s;
            txd_r   <= txd_s;
            br_en_r <= br_en_s;
        end
    end

    // Next-state and next-output logic; the bit counter doubles as stop counter
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        par_s   = par_r;
        txd_s   = txd_r;
        br_en_s = br_en_r;
        case (state_r)
            ST_IDLE: begin
                txd_s   = 1'b1;
                br_en_s = 1'b0;
                if (tx_valid) begin
                    shift_s = tx_data & DATA_MASK;
                    cnt_s   = 4'd0;
                    par_s   = 1'b0;
                    txd_s   = 1'b0;
                    br_en_s = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_br_stb) begin
                    txd_s   = shift_r[0];
                    shift_s = {1'b0, shift_r[7:1]};
                    par_s   = par_fold(par_r, shift_r[0]);
                    cnt_s   = 4'd1;
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tx_br_stb) begin
                    if (cnt_r < DATA_BITS_C) begin
                        txd_s   = shift_r[0];
                        shift_s = {1'b0, shift_r[7:1]};
                        par_s   = par_fold(par_r, shift_r[0]);
                        cnt_s   = cnt_r + 4'd1;
                    end else if (PARITY_EN_C) begin
                        txd_s   = par_r ^ PARITY_ODD_C;
                        state_s = ST_PARITY;
                    end else begin
                        txd_s   = 1'b1;
                        cnt_s   = 4'd1;
                        state_s = ST_STOP;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tx_br_stb) begin
                    txd_s   = 1'b1;
                    cnt_s   = 4'd1;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                txd_s = 1'b1;
                if (tx_br_stb) begin
                    if (cnt_r < STOP_BITS_C) begin
                        cnt_s = cnt_r + 4'd1;
                    end else begin
                        br_en_s = 1'b0;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                txd_s   = 1'b1;
                br_en_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = (state_r == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign txd      = txd_r;
    assign tx_br_en = br_en_r;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter that serialises parallel bytes onto `txd` using the bit-period strobe from the shared baud-rate generator. It sits beside the receiver in the UART top. It owns `tx_br_en` and advances one bit per `tx_br_stb`. Upstream logic hands it one character at a time through a valid/ready handshake. Frame format is LSB-first: start bit, 5–8 data bits, optional parity, then 1 or 2 stop bits.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 5–8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: stop bits per frame; legal 1 or 2.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `tx_valid` in 1: upstream holds a character on `tx_data`.
- `tx_data` in 8: character; only bits [DATA_BITS-1:0] are used.
- `tx_ready` out 1: transmitter can accept a character (high only in IDLE).
- `tx_br_en` out 1: enable to the baud generator; a low level clears its counter.
- `tx_br_stb` in 1: one-cycle strobe marking the end of each bit period.
- `txd` out 1: serial line; idles high.
- `tx_busy` out 1: a frame is in progress; equals ~`tx_ready`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state register, `txd`, `tx_br_en`, the shift register, the bit counter and the parity accumulator are all flops. `tx_ready` and `tx_busy` decode combinationally from the state.
- Reset values: state IDLE, `txd`=1, `tx_br_en`=0, `tx_ready`=1, `tx_busy`=0, shift register 0, counters 0.
- IDLE:
  - `txd`=1, `tx_br_en`=0.
  - On `tx_valid & tx_ready`, at the same edge: latch `tx_data[DATA_BITS-1:0]` into the shift register, clear the bit counter and parity, set `txd`=0 and `tx_br_en`=1, and go to START.
- START, on `tx_br_stb`:
  - `txd` ← shift[0].
  - Shift right and fold the bit into parity.
  - Bit counter ← 1.
  - Go to DATA.
- DATA, on `tx_br_stb`:
  - If bit counter < DATA_BITS: emit the next LSB, increment the counter, update parity.
  - Else, with PARITY_EN: `txd` ← parity ^ PARITY_ODD and go to PARITY.
  - Else, without PARITY_EN: `txd` ← 1, go to STOP, stop counter ← 1.
- PARITY, on `tx_br_stb`: `txd` ← 1, go to STOP, stop counter ← 1.
- STOP, on `tx_br_stb`:
  - If stop counter < STOP_BITS: increment it; `txd` stays 1.
  - Else: go to IDLE and set `tx_br_en` ← 0.
- `tx_br_stb` is ignored in IDLE.
- `tx_valid` and `tx_data` are ignored while busy; later changes to `tx_data` do not affect the frame in flight.
- Parity is the XOR of the DATA_BITS transmitted bits only.

## Timing
- Bit period P = generator threshold + 1 clocks. The generator's first strobe arrives P−1 cycles after the edge that raises `tx_br_en`, so the start bit lasts exactly P clocks.
- Every data, parity and stop bit lasts exactly P clocks. `txd` changes only on the edge that consumes a strobe.
- Accept-to-start-bit latency: `txd` falls on the accepting edge, so it is low in the cycle after the handshake.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × P clocks, measured from `txd` falling to IDLE re-entry.
- Back-to-back frames:
  - IDLE lasts at least 1 cycle, so the last stop bit is high for P+1 clocks minimum when `tx_valid` is held.
  - `tx_br_en` is low for at least 1 cycle between frames, which resets the generator.
- Reset mid-frame: asynchronously forces `txd`=1, `tx_br_en`=0 and state IDLE. The frame is aborted, not resumed; `tx_ready`=1 in the first cycle after release.
- Handshake: data transfers only on an edge where `tx_valid` & `tx_ready` are both 1. Holding `tx_valid` without `tx_ready` transfers nothing.

## Test plan
- 8N1, generator threshold 87 (P=88), send 0x55: `txd` = 0,1,0,1,0,1,0,1,0,1, each held 88 clk; `tx_busy` high 880 clk; `tx_br_en` drops on the cycle after the stop strobe.
- PARITY_EN=1, PARITY_ODD=0, send 0x07: bits 0,1,1,1,0,0,0,0,0, then parity 1, then stop 1. Repeat with PARITY_ODD=1: parity bit 0.
- DATA_BITS=5, STOP_BITS=2, send 0xFF: start, five 1s, then stop high for 2×P; frame = 8×P clk; bits 7:5 of `tx_data` never appear on `txd`.
- Back-to-back 0xA5 then 0x3C with `tx_valid` held: second start bit begins 1 clk after the first frame's final strobe edge; the second frame is bit-exact; `tx_data` changed mid-frame leaves the first frame unaffected.
- Assert `rstn` low during data bit 3 of 0x00: `txd`=1 and `tx_br_en`=0 immediately; after release, `tx_ready`=1 and a new 0x81 frame transmits correctly.
- Force a spurious `tx_br_stb` pulse in IDLE: no state change, and `txd` stays 1.
